// File: rtl/alu_seq_pkg.sv
// Shared opcode, FSM state and flag definitions for the sequential ALU.
// The ALU and its multiplier datapath both use these definitions.
package alu_seq_pkg;

  typedef enum logic [3:0] {
    OP_AND      = 4'd0,
    OP_OR       = 4'd1,
    OP_NOR      = 4'd2,
    OP_ADD      = 4'd3,
    OP_SUB      = 4'd4,
    OP_INC      = 4'd5,
    OP_MULTPLUS = 4'd6,
    OP_MOV      = 4'd7
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_FIN  = 2'd2
  } alu_state_e;

  typedef struct packed {
    logic zero;
    logic carry;
    logic overflow;
  } alu_flags_t;

endpackage

// File: rtl/alu_seq_if.sv
// Issue/result bundle between the register-file read stage and the ALU.
// The master drives the operation; the slave returns the result and flags.
interface alu_seq_if #(
  parameter int WIDTH = 32
);
  logic             Start;
  logic [3:0]       ALUOperation;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Ready;
  logic             Done;
  logic [WIDTH-1:0] ALUResult;
  logic             Zero;
  logic             Carry;
  logic             Overflow;

  modport master (
    output Start, ALUOperation, A, B,
    input  Ready, Done, ALUResult, Zero, Carry, Overflow
  );

  modport slave (
    input  Start, ALUOperation, A, B,
    output Ready, Done, ALUResult, Zero, Carry, Overflow
  );
endinterface

// File: rtl/alu_seq_multiplier.sv
// Iterative shift-add multiplier keeping the low WIDTH bits of the product.
// Latency WIDTH cycles after start; start is only honoured when not busy.
module alu_seq_multiplier #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  logic [WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0] mplier_q;
  logic [WIDTH-1:0] acc_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;
  logic             last_iter;

  // done marks the cycle whose edge performs the final iteration, so the
  // product is complete in the cycle that follows.
  assign last_iter = busy_q && (cnt_q == CNT_W'(WIDTH - 1));
  assign busy      = busy_q;
  assign done      = last_iter;
  assign product   = acc_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
    end else if (start && !busy_q) begin
      mcand_q  <= a;
      mplier_q <= b;
      acc_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b1;
    end else if (busy_q) begin
      if (mplier_q[0]) begin
        acc_q <= acc_q + mcand_q;
      end
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + CNT_W'(1);
      if (last_iter) begin
        busy_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Registered WIDTH-bit ALU: single-cycle ops report Done one cycle after accept,
// MULTPLUS reports WIDTH+2 cycles after accept; Ready drops while multiplying.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic     clk,
  input  logic     reset,
  alu_seq_if.slave bus
);

  alu_state_e       state_q;
  alu_state_e       state_d;

  logic             accept;
  logic             mul_start;
  logic             mul_busy;
  logic             mul_done;
  logic [WIDTH-1:0] mul_product;
  logic [WIDTH-1:0] mplus_res;

  logic [WIDTH:0]   add_sum;
  logic [WIDTH:0]   sub_diff;
  logic [WIDTH:0]   inc_sum;
  logic [WIDTH-1:0] op_res;
  alu_flags_t       op_flags;

  logic [WIDTH-1:0] result_q;
  alu_flags_t       flags_q;
  logic             done_q;

  assign bus.Ready = (state_q == ST_IDLE) && !mul_busy;
  assign accept    = bus.Start && bus.Ready;
  assign mul_start = accept && (bus.ALUOperation == OP_MULTPLUS);

  alu_seq_multiplier #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_mult (
    .clk     (clk),
    .reset   (reset),
    .start   (mul_start),
    .a       (bus.A),
    .b       (bus.B),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_product)
  );

  // Extra top bit carries the unsigned carry/borrow out of each operation.
  assign add_sum   = {1'b0, bus.A} + {1'b0, bus.B};
  assign sub_diff  = {1'b0, bus.A} - {1'b0, bus.B};
  assign inc_sum   = {1'b0, bus.B} + {{WIDTH{1'b0}}, 1'b1};
  assign mplus_res = mul_product + {{(WIDTH-1){1'b0}}, 1'b1};

  always_comb begin
    op_res            = '0;
    op_flags.carry    = 1'b0;
    op_flags.overflow = 1'b0;
    case (bus.ALUOperation)
      OP_AND: op_res = bus.A & bus.B;
      OP_OR:  op_res = bus.A | bus.B;
      OP_NOR: op_res = ~(bus.A | bus.B);
      OP_ADD: begin
        op_res            = add_sum[WIDTH-1:0];
        op_flags.carry    = add_sum[WIDTH];
        op_flags.overflow = (bus.A[WIDTH-1] == bus.B[WIDTH-1]) &&
                            (add_sum[WIDTH-1] != bus.A[WIDTH-1]);
      end
      OP_SUB: begin
        // Carry is NOT borrow, i.e. set when A >= B unsigned.
        op_res            = sub_diff[WIDTH-1:0];
        op_flags.carry    = ~sub_diff[WIDTH];
        op_flags.overflow = (bus.A[WIDTH-1] != bus.B[WIDTH-1]) &&
                            (sub_diff[WIDTH-1] != bus.A[WIDTH-1]);
      end
      OP_INC: begin
        op_res            = inc_sum[WIDTH-1:0];
        op_flags.carry    = inc_sum[WIDTH];
        op_flags.overflow = !bus.B[WIDTH-1] && inc_sum[WIDTH-1];
      end
      OP_MOV: op_res = bus.B;
      default: op_res = '0;
    endcase
    op_flags.zero = (op_res == '0);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (mul_start) state_d = ST_MUL;
      ST_MUL:  if (mul_done)  state_d = ST_FIN;
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result_q         <= '0;
      flags_q.zero     <= 1'b1;
      flags_q.carry    <= 1'b0;
      flags_q.overflow <= 1'b0;
      done_q           <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state_q == ST_FIN) begin
        result_q         <= mplus_res;
        flags_q.zero     <= (mplus_res == '0);
        flags_q.carry    <= 1'b0;
        flags_q.overflow <= 1'b0;
        done_q           <= 1'b1;
      end else if (accept && !mul_start) begin
        result_q <= op_res;
        flags_q  <= op_flags;
        done_q   <= 1'b1;
      end
    end
  end

  assign bus.Done      = done_q;
  assign bus.ALUResult = result_q;
  assign bus.Zero      = flags_q.zero;
  assign bus.Carry     = flags_q.carry;
  assign bus.Overflow  = flags_q.overflow;

endmodule

// File: tb/tb_alu_seq.sv
// Randomised bench for alu_seq with a plain-arithmetic reference model.
module tb_alu_seq;
  localparam int W = 32;

  localparam logic [3:0] T_AND  = 4'd0;
  localparam logic [3:0] T_OR   = 4'd1;
  localparam logic [3:0] T_NOR  = 4'd2;
  localparam logic [3:0] T_ADD  = 4'd3;
  localparam logic [3:0] T_SUB  = 4'd4;
  localparam logic [3:0] T_INC  = 4'd5;
  localparam logic [3:0] T_MULT = 4'd6;
  localparam logic [3:0] T_MOV  = 4'd7;
  localparam logic [3:0] T_BAD  = 4'd15;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;

  alu_seq_if #(.WIDTH(W)) bus();
  alu_seq #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] res;
    logic         z;
    logic         c;
    logic         v;
  } exp_t;

  function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t        e;
    logic [63:0] wide;
    longint      sx;
    int          ia;
    int          ib;
    ia = a;
    ib = b;
    e.res = '0;
    e.c = 1'b0;
    e.v = 1'b0;
    case (op)
      T_AND: e.res = a & b;
      T_OR:  e.res = a | b;
      T_NOR: e.res = ~(a | b);
      T_ADD: begin
        wide  = {32'd0, a} + {32'd0, b};
        e.res = wide[31:0];
        e.c   = (wide >= 64'h1_0000_0000);
        sx    = longint'(ia) + longint'(ib);
        e.v   = (sx != longint'(int'(sx)));
      end
      T_SUB: begin
        e.res = a - b;
        e.c   = (a >= b);
        sx    = longint'(ia) - longint'(ib);
        e.v   = (sx != longint'(int'(sx)));
      end
      T_INC: begin
        e.res = b + 32'd1;
        e.c   = (b == 32'hFFFF_FFFF);
        sx    = longint'(ib) + 64'sd1;
        e.v   = (sx != longint'(int'(sx)));
      end
      T_MULT: begin
        wide  = {32'd0, a} * {32'd0, b};
        wide  = wide + 64'd1;
        e.res = wide[31:0];
      end
      T_MOV: e.res = b;
      default: e.res = '0;
    endcase
    e.z = (e.res == '0);
    return e;
  endfunction

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_out(input string name, input exp_t e);
    chk({name, "_done"},  32'(bus.Done), 32'd1);
    chk({name, "_res"},   bus.ALUResult, e.res);
    chk({name, "_zero"},  32'(bus.Zero), 32'(e.z));
    chk({name, "_carry"}, 32'(bus.Carry), 32'(e.c));
    chk({name, "_ovf"},   32'(bus.Overflow), 32'(e.v));
    chk({name, "_ready"}, 32'(bus.Ready), 32'd1);
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 4))
      0: return '0;
      1: return '1;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  task automatic single(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input string name);
    exp_t e;
    e = model(op, a, b);
    @(negedge clk);
    bus.Start = 1'b1; bus.ALUOperation = op; bus.A = a; bus.B = b;
    @(negedge clk);
    bus.Start = 1'b0; bus.A = $urandom; bus.B = $urandom;
    check_out(name, e);
    @(negedge clk);
    chk({name, "_done_clr"}, 32'(bus.Done), 32'd0);
  endtask

  task automatic mult(input logic [W-1:0] a, input logic [W-1:0] b, input string name);
    exp_t e;
    int   waited;
    int   low;
    e = model(T_MULT, a, b);
    @(negedge clk);
    bus.Start = 1'b1; bus.ALUOperation = T_MULT; bus.A = a; bus.B = b;
    @(negedge clk);
    bus.Start = 1'b0; bus.ALUOperation = 4'($urandom); bus.A = $urandom; bus.B = $urandom;
    waited = 0;
    low = 0;
    while (bus.Done !== 1'b1 && waited < 100) begin
      if (bus.Ready === 1'b0) low++;
      if (waited == 5) begin
        bus.Start = 1'b1; bus.ALUOperation = T_ADD; bus.A = 32'd1; bus.B = 32'd1;
      end else begin
        bus.Start = 1'b0;
      end
      @(negedge clk);
      waited++;
    end
    bus.Start = 1'b0;
    chk({name, "_latency"},   32'(waited), 32'(W + 1));
    chk({name, "_ready_low"}, 32'(low), 32'(W + 1));
    check_out(name, e);
    @(negedge clk);
    chk({name, "_done_clr"}, 32'(bus.Done), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] b2b_ops [6];
    exp_t       b2b_exp [6];
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic [3:0]   rop;
    int           dones;

    reset = 1'b0;
    bus.Start = 1'b0; bus.ALUOperation = '0; bus.A = '0; bus.B = '0;
    #1 reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_res",   bus.ALUResult, 32'd0);
    chk("rst_zero",  32'(bus.Zero), 32'd1);
    chk("rst_ready", 32'(bus.Ready), 32'd1);
    chk("rst_done",  32'(bus.Done), 32'd0);
    chk("rst_carry", 32'(bus.Carry), 32'd0);
    chk("rst_ovf",   32'(bus.Overflow), 32'd0);
    reset = 1'b0;

    single(T_ADD, 32'd7, 32'd5, "add_7_5");
    single(T_ADD, 32'hFFFF_FFFF, 32'd1, "add_wrap");
    single(T_ADD, 32'h7FFF_FFFF, 32'd1, "add_ovf");
    single(T_SUB, 32'd3, 32'd5, "sub_neg");
    single(T_SUB, 32'd9, 32'd9, "sub_eq");
    single(T_SUB, 32'h8000_0000, 32'd1, "sub_ovf");
    single(T_INC, 32'd0, 32'hFFFF_FFFF, "inc_wrap");
    single(T_INC, 32'd0, 32'h7FFF_FFFF, "inc_ovf");

    mult(32'd6, 32'd7, "mul_6_7");
    mult(32'd0, $urandom, "mul_zero");
    mult(32'hFFFF_FFFF, 32'hFFFF_FFFF, "mul_max");

    b2b_ops = '{T_AND, T_OR, T_NOR, T_INC, T_MOV, T_BAD};
    for (int i = 0; i <= 6; i++) begin
      @(negedge clk);
      if (i > 0) check_out($sformatf("b2b%0d", i - 1), b2b_exp[i-1]);
      if (i < 6) begin
        ra = $urandom;
        rb = $urandom;
        b2b_exp[i] = model(b2b_ops[i], ra, rb);
        bus.Start = 1'b1; bus.ALUOperation = b2b_ops[i]; bus.A = ra; bus.B = rb;
      end else begin
        bus.Start = 1'b0;
      end
    end
    @(negedge clk);
    chk("b2b_done_clr", 32'(bus.Done), 32'd0);

    for (int i = 0; i < 40; i++) begin
      rop = 4'($urandom_range(0, 15));
      ra  = pick();
      rb  = pick();
      if (rop == T_MULT) mult(ra, rb, $sformatf("rnd%0d_mul", i));
      else single(rop, ra, rb, $sformatf("rnd%0d_op%0d", i, rop));
    end

    single(T_ADD, 32'hFFFF_FFFF, 32'd2, "pre_abort");
    @(negedge clk);
    bus.Start = 1'b1; bus.ALUOperation = T_MULT; bus.A = 32'hFFFF_FFFF; bus.B = 32'd3;
    @(negedge clk);
    bus.Start = 1'b0;
    repeat (9) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("abort_res",   bus.ALUResult, 32'd0);
    chk("abort_zero",  32'(bus.Zero), 32'd1);
    chk("abort_carry", 32'(bus.Carry), 32'd0);
    chk("abort_ovf",   32'(bus.Overflow), 32'd0);
    chk("abort_ready", 32'(bus.Ready), 32'd1);
    chk("abort_done",  32'(bus.Done), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.Done === 1'b1) dones++;
    end
    chk("abort_no_done", 32'(dones), 32'd0);
    chk("abort_ready_idle", 32'(bus.Ready), 32'd1);
    single(T_ADD, 32'd7, 32'd5, "post_abort_add");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
Parametrised, registered ALU for the next datapath revision. It generalises the combinational ALU to WIDTH bits and adds a valid/ready issue handshake. Logic ops, add/sub, INC and MOV complete in one cycle; MULTPLUS runs on an iterative shift-add multiplier. It adds Overflow and Carry flags and sits between the register-file read stage and the write-back mux.

Parameters:
WIDTH, 32, operand and result width in bits (minimum 4)
CNT_W, $clog2(WIDTH+1), width of the multiplier iteration counter (derived; do not override)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
Start  input  1  issue strobe; operation accepted on a rising edge where Start=1 and Ready=1
ALUOperation  input  4  opcode: AND=0, OR=1, NOR=2, ADD=3, SUB=4, INC=5, MULTPLUS=6, MOV=7, others invalid
A  input  WIDTH  operand A, sampled only on accept
B  input  WIDTH  operand B, sampled only on accept
Ready  output  1  block can accept an operation this cycle
Done  output  1  one-cycle pulse; ALUResult and flags are valid and updated
ALUResult  output  WIDTH  registered result, held until the next Done
Zero  output  1  1 when ALUResult==0, updated with Done
Carry  output  1  carry-out of ADD/INC; NOT borrow for SUB; 0 for all other ops
Overflow  output  1  signed overflow for ADD/SUB/INC; 0 for all other ops

Behaviour:
- Reset (asynchronous, active-high): state=IDLE, Ready=1, Done=0, ALUResult=0, Zero=1, Carry=0, Overflow=0, multiplier registers=0.
- FSM states: IDLE, MUL, FIN.
- IDLE + accept of a single-cycle op: result computed and registered on the accept edge. Done=1 in the following cycle. Ready stays 1, so back-to-back issue is allowed (throughput 1/cycle).
- IDLE + accept of MULTPLUS: latch A and B, clear the product accumulator, counter=0, then go to MUL. Ready=0 from the next cycle.
- MUL: each cycle, if multiplier bit0 is 1, add the multiplicand to the accumulator. Shift the multiplicand left, shift the multiplier right, and increment the counter. After WIDTH iterations go to FIN.
- FIN (1 cycle): ALUResult = low WIDTH bits of (product + 1), computed modulo 2^WIDTH. Register the flags, pulse Done on the next cycle, return to IDLE, Ready=1.
- MULTPLUS latency: accept at edge 0, Done high during cycle WIDTH+2. No other issue is accepted in between.
- Arithmetic:
  - all results are truncated to WIDTH bits
  - ADD and SUB carry is taken from a WIDTH+1-bit sum
  - SUB Carry=1 when A>=B (unsigned)
  - INC computes B+1; MOV returns B
  - NOR computes ~(A|B)
- Invalid opcode: accepted as a single-cycle op; ALUResult=0, Zero=1, Carry=0, Overflow=0, Done pulses.
- Start while Ready=0: ignored. It is not queued and causes no error.
- Done is never held high for two cycles by the same operation. Consecutive single-cycle issues give consecutive Done pulses.
- Inputs A, B and ALUOperation may change freely after accept without affecting an in-flight multiply.
- Reset asserted mid-multiply: immediate abort to the reset values. No Done is produced for the aborted op.
- Edge values: WIDTH'hFFFF..F + 1 wraps to 0 with Zero=1 and Carry=1. MULTPLUS with A=0 gives result 1. MULTPLUS of max*max gives 2 (low bits of 1 plus 1).

Decomposition:
- Shared package / include alu_defs.vh holds:
  - the opcode localparams (AND..MOV)
  - the FSM state encodings
- Sub-module seq_multiplier (WIDTH): holds the shift-add datapath and counter, with interface start, busy, done, a, b, product[WIDTH-1:0].
- alu_seq keeps the FSM, the single-cycle ops, the +1 step and the flag logic.

Test Plan:
- WIDTH=32. After reset: ALUResult=0, Zero=1, Ready=1, Done=0. Issue ADD A=7 B=5 → Done next cycle, ALUResult=12, Zero=0, Carry=0.
- ADD A=32'hFFFFFFFF B=1 → ALUResult=0, Zero=1, Carry=1, Overflow=0. ADD A=32'h7FFFFFFF B=1 → 32'h80000000, Overflow=1.
- SUB A=3 B=5 → ALUResult=32'hFFFFFFFE, Carry=0. SUB A=9 B=9 → 0, Zero=1, Carry=1.
- MULTPLUS A=6 B=7 → Ready low for 33 cycles, Done in cycle 34, ALUResult=43. A second Start during busy with ADD 1+1 → ignored, no extra Done.
- Back-to-back AND, OR, NOR, INC, MOV and invalid op 4'hF over 6 consecutive cycles → 6 consecutive Done pulses with correct values; op 4'hF gives 0 and Zero=1.
- Start MULTPLUS, assert reset at cycle 10 → all outputs return to reset values asynchronously, no Done. The next ADD after release works normally.
